lf_adder_pipe: RTL

Parametrised, pipelined Ladner-Fischer prefix adder/subtractor with valid/ready handshakes on both sides. It generalises the fixed 8-bit combinational prefix adder to any power-of-two width, adds a subtract mode and signed-overflow flag, and registers every prefix level for one-result-per-cycle throughput. It sits in the datapath as a drop-in arithmetic stage between producer/consumer blocks that use the team's valid/ready convention.

---
 rtl/lf_pkg.sv | 16 +
 rtl/lf_prefix_cell.sv | 12 +
 rtl/lf_adder_pipe.sv | 124 ++++++++++++
 3 files changed

// File: rtl/lf_pkg.sv
// Shared types and the Ladner-Fischer (G,P) combine operator.
package lf_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic gp_t lf_combine(gp_t hi, gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/lf_prefix_cell.sv
// One active prefix node: combinational (G,P) composition.
module lf_prefix_cell
  import lf_pkg::*;
(
  input  gp_t hi_i,
  input  gp_t lo_i,
  output gp_t gp_o
);

  assign gp_o = lf_combine(hi_i, lo_i);

endmodule

// File: rtl/lf_adder_pipe.sv
// Pipelined Ladner-Fischer adder/subtractor, one register per prefix level,
// valid/ready on both sides with a single global advance enable.
module lf_adder_pipe
  import lf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LOG2W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int L = LOG2W;

  logic en;

  logic [L:0][WIDTH-1:0] g_q, g_d;
  logic [L:0][WIDTH-1:0] p_q, p_d;
  logic [L:0][WIDTH-1:0] r_q, r_d;
  logic [L:0]            c_q, c_d;
  logic [L:0]            v_q, v_d;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, ovf_q;
  logic             cout_d, ovf_d;

  logic [WIDTH-1:0] b_x, g0, p0;
  logic             c0;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en && !rst;

  assign b_x = in_b ^ {WIDTH{in_sub}};
  assign c0  = in_sub | in_cin;
  assign p0  = in_a ^ b_x;
  assign g0  = in_a & b_x;

  // Idle slots hold their old data so X inputs never enter the pipe.
  assign v_d[0] = in_valid;
  assign g_d[0] = in_valid ? {g0[WIDTH-1:1], g0[0] | (p0[0] & c0)} : g_q[0];
  assign p_d[0] = in_valid ? p0 : p_q[0];
  assign r_d[0] = in_valid ? p0 : r_q[0];
  assign c_d[0] = in_valid ? c0 : c_q[0];

  for (genvar k = 1; k <= L; k++) begin : g_lvl
    assign v_d[k] = v_q[k-1];
    assign r_d[k] = r_q[k-1];
    assign c_d[k] = c_q[k-1];
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (((i >> (k-1)) & 1) == 1) begin : g_node
        localparam int J = ((i >> (k-1)) << (k-1)) - 1;
        gp_t hi, lo, o;
        assign hi.g = g_q[k-1][i];
        assign hi.p = p_q[k-1][i];
        assign lo.g = g_q[k-1][J];
        assign lo.p = p_q[k-1][J];
        lf_prefix_cell u_cell (
          .hi_i (hi),
          .lo_i (lo),
          .gp_o (o)
        );
        assign g_d[k][i] = o.g;
        assign p_d[k][i] = o.p;
      end else begin : g_pass
        assign g_d[k][i] = g_q[k-1][i];
        assign p_d[k][i] = p_q[k-1][i];
      end
    end
  end

  // Group propagate of the last level has no consumer.
  logic unused_p;
  assign unused_p = ^p_q[L];

  logic [WIDTH-1:0] carry;
  assign carry  = {g_q[L][WIDTH-2:0], c_q[L]};
  assign sum_d  = r_q[L] ^ carry;
  assign cout_d = g_q[L][WIDTH-1];
  assign ovf_d  = g_q[L][WIDTH-1] ^ carry[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q         <= '0;
      g_q         <= '0;
      p_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (en) begin
      v_q         <= v_d;
      g_q         <= g_d;
      p_q         <= p_d;
      r_q         <= r_d;
      c_q         <= c_d;
      out_valid_q <= v_q[L];
      if (v_q[L]) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule
